// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one 10-bit ripple adder among NUM_REQ requesters.
// Each operation runs IDLE -> ADD -> RESP: grant is high in ADD, done is high in RESP.

module adder_two (
  input  logic [9:0]  a_i,
  input  logic [9:0]  b_i,
  output logic [10:0] sum_o
);

  logic [10:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 10; i++) begin : g_fa
    assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign sum_o[10] = carry[10];

endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*10-1:0]   op_a_flat,
  input  logic [NUM_REQ*10-1:0]   op_b_flat,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [10:0]             result,
  output logic [ID_W-1:0]         result_id,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LAST_INIT = ID_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      last_id_q, last_id_d;
  logic [9:0]           opa_q, opa_d;
  logic [9:0]           opb_q, opb_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [10:0]          result_q, result_d;
  logic [ID_W-1:0]      result_id_q, result_id_d;

  logic [9:0]           op_a [NUM_REQ];
  logic [9:0]           op_b [NUM_REQ];
  logic [ID_W-1:0]      win;
  logic [10:0]          sum;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_a[i] = op_a_flat[10*i +: 10];
    assign op_b[i] = op_b_flat[10*i +: 10];
  end

  // First set request bit after last, wrapping; the descending scan lets the
  // nearest candidate overwrite farther ones.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (r[ID_W'(idx)]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign win = rr_pick(req, last_id_q);

  adder_two u_adder (
    .a_i   (opa_q),
    .b_i   (opb_q),
    .sum_o (sum)
  );

  always_comb begin
    // NOTE: every _d gets its hold/idle value first so no path infers a latch.
    state_d     = state_q;
    last_id_d   = last_id_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    grant_d     = '0;
    done_d      = '0;
    result_d    = result_q;
    result_id_d = result_id_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          opa_d     = op_a[win];
          opb_d     = op_b[win];
          grant_d   = ONE << win;
          last_id_d = win;
          state_d   = ADD;
        end
      end
      ADD: begin
        // last_id_q still names the requester captured in IDLE.
        result_d    = sum;
        result_id_d = last_id_q;
        done_d      = ONE << last_id_q;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_id_q   <= LAST_INIT;
      opa_q       <= '0;
      opb_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      result_q    <= '0;
      result_id_q <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_id = result_id_q;
  assign busy      = (state_q != IDLE);

endmodule
